// File: rtl/hazard_tracker_pkg.sv
// rtl/hazard_tracker_pkg.sv - shared pipeline types and constants for the hazard tracker
// Contents:
//   entry_t       one tracked post-decode stage {valid, wa, regwrite, load, pcwrite}
//   FWD_RF        forward-select code meaning "use the register file"
//   DEPTH_MIN/MAX legal range of tracked stages
//   fwd_code()    forward-select code for a given stage number
package hazard_tracker_pkg;

    localparam int DEPTH_MIN = 3;
    localparam int DEPTH_MAX = 6;

    // Entries carry a fixed-width address field so the struct can live here;
    // the tracker only looks at the low AW bits.
    localparam int WA_MAX = 8;

    localparam int              FWD_W  = 3;
    localparam logic [FWD_W-1:0] FWD_RF = 3'd0;

    typedef struct packed {
        logic              valid;
        logic [WA_MAX-1:0] wa;
        logic              regwrite;
        logic              load;
        logic              pcwrite;
    } entry_t;

    localparam entry_t ENTRY_BUBBLE = '0;

    function automatic logic [FWD_W-1:0] fwd_code(input int stage);
        return FWD_W'(stage);
    endfunction

endpackage

// File: rtl/hazard_tracker_if.sv
// rtl/hazard_tracker_if.sv - decode/execute hazard bundle between pipeline and hazard tracker
// Signals:
//   issue_valid/issue_wa/issue_regwrite/issue_load/issue_pcwrite  decode instruction
//   src_d, src_d_used   decode source addresses and per-source valid mask
//   src_e               execute-stage source addresses
//   branch_taken_e      execute resolved a taken branch
//   stall_f/stall_d/flush_d/flush_e  pipeline control back to the pipeline
//   fwd_sel             per execute source forward select (3 bits each)
//   stall_cnt/flush_cnt saturating performance counters
// Modports: master = pipeline side, slave = hazard tracker.
interface hazard_tracker_if
    import hazard_tracker_pkg::*;
#(
    parameter int AW   = 4,
    parameter int NSRC = 3,
    parameter int CW   = 16
);

    logic                    issue_valid;
    logic [AW-1:0]           issue_wa;
    logic                    issue_regwrite;
    logic                    issue_load;
    logic                    issue_pcwrite;
    logic [NSRC*AW-1:0]      src_d;
    logic [NSRC-1:0]         src_d_used;
    logic [NSRC*AW-1:0]      src_e;
    logic                    branch_taken_e;

    logic                    stall_f;
    logic                    stall_d;
    logic                    flush_d;
    logic                    flush_e;
    logic [NSRC*FWD_W-1:0]   fwd_sel;
    logic [CW-1:0]           stall_cnt;
    logic [CW-1:0]           flush_cnt;

    modport master (
        output issue_valid, issue_wa, issue_regwrite, issue_load, issue_pcwrite,
        output src_d, src_d_used, src_e, branch_taken_e,
        input  stall_f, stall_d, flush_d, flush_e, fwd_sel, stall_cnt, flush_cnt
    );

    modport slave (
        input  issue_valid, issue_wa, issue_regwrite, issue_load, issue_pcwrite,
        input  src_d, src_d_used, src_e, branch_taken_e,
        output stall_f, stall_d, flush_d, flush_e, fwd_sel, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_tracker_reg_match.sv
// rtl/hazard_tracker_reg_match.sv - register-address comparator gated by entry eligibility
// Ports:
//   i_elig   entry may take part in matching
//   i_wa     entry destination address
//   i_src    source address being checked
//   o_match  i_elig and addresses equal
module reg_match #(
    parameter int AW = 4
) (
    input  logic          i_elig,
    input  logic [AW-1:0] i_wa,
    input  logic [AW-1:0] i_src,
    output logic          o_match
);

    assign o_match = i_elig && (i_wa == i_src);

endmodule

// File: rtl/hazard_tracker.sv
// rtl/hazard_tracker.sv - pipeline hazard tracker: forwarding, load-use and PC-write stalls
// Ports:
//   clk    sole clock, rising edge
//   reset  synchronous active-low reset
//   bus    hazard_tracker_if slave: decode/execute inputs, stall/flush/forward outputs,
//          stall and flush performance counters
// Stage numbering: 1 = E, 2 = M, ..., DEPTH = W.
module hazard_tracker
    import hazard_tracker_pkg::*;
#(
    parameter int AW    = 4,
    parameter int DEPTH = 3,
    parameter int NSRC  = 3,
    parameter int PCREG = 15,
    parameter int CW    = 16
) (
    input  logic             clk,
    input  logic             reset,
    hazard_tracker_if.slave  bus
);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("hazard_tracker: DEPTH out of range");
    end
    if (AW > WA_MAX) begin : g_bad_aw
        $error("hazard_tracker: AW wider than entry address field");
    end

    localparam logic [CW-1:0] CNT_MAX = '1;

    entry_t                     r_pipe [1:DEPTH];
    logic [CW-1:0]              r_stall_cnt;
    logic [CW-1:0]              r_flush_cnt;

    logic [DEPTH:1]             w_elig;
    // Column 1 holds the load-use compare (stage 1 vs decode sources);
    // columns 2..DEPTH hold the forwarding compares against execute sources.
    logic [NSRC-1:0][DEPTH:1]   w_hit;
    logic                       w_load_use;
    logic                       w_pc_busy;
    logic                       w_stall_f;
    logic                       w_stall_d;
    logic                       w_flush_d;
    logic                       w_flush_e;
    logic [NSRC*FWD_W-1:0]      w_fwd_sel;
    logic                       w_unused;

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        assign w_elig[k] = r_pipe[k].valid && r_pipe[k].regwrite &&
                           (r_pipe[k].wa[AW-1:0] != AW'(PCREG));

        for (genvar i = 0; i < NSRC; i++) begin : g_src
            if (k == 1) begin : g_load_use
                reg_match #(.AW(AW)) u_match (
                    .i_elig  (w_elig[1] && r_pipe[1].load && bus.src_d_used[i]),
                    .i_wa    (r_pipe[1].wa[AW-1:0]),
                    .i_src   (bus.src_d[i*AW +: AW]),
                    .o_match (w_hit[i][1])
                );
            end else begin : g_forward
                reg_match #(.AW(AW)) u_match (
                    .i_elig  (w_elig[k]),
                    .i_wa    (r_pipe[k].wa[AW-1:0]),
                    .i_src   (bus.src_e[i*AW +: AW]),
                    .o_match (w_hit[i][k])
                );
            end
        end
    end

    always_comb begin
        w_load_use = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            w_load_use = w_load_use | w_hit[i][1];
        end
    end

    // A PC write holds fetch until it reaches W; once it sits in W the new
    // PC is available, so stage DEPTH is deliberately left out.
    always_comb begin
        w_pc_busy = bus.issue_valid && bus.issue_pcwrite;
        for (int k = 1; k < DEPTH; k++) begin
            w_pc_busy = w_pc_busy | (r_pipe[k].valid && r_pipe[k].pcwrite);
        end
    end

    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        if (reset) begin
            if (bus.branch_taken_e) begin
                // A taken branch squashes decode and execute; stalling would
                // hold the wrong-path fetch, so stalls are dropped.
                w_flush_d = 1'b1;
                w_flush_e = 1'b1;
            end else begin
                w_stall_f = w_load_use | w_pc_busy;
                w_stall_d = w_load_use;
                w_flush_e = w_load_use;
                w_flush_d = w_pc_busy;
            end
        end
    end

    // Nearest producer wins: scan from W towards M so the youngest match
    // overwrites older ones.
    always_comb begin
        w_fwd_sel = '0;
        if (reset) begin
            for (int i = 0; i < NSRC; i++) begin
                w_fwd_sel[i*FWD_W +: FWD_W] = FWD_RF;
                for (int k = DEPTH; k >= 2; k--) begin
                    if (w_hit[i][k]) begin
                        w_fwd_sel[i*FWD_W +: FWD_W] = fwd_code(k);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_pipe[k] <= ENTRY_BUBBLE;
            end
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (bus.issue_valid && !w_flush_e) begin
                r_pipe[1] <= '{valid:    1'b1,
                               wa:       WA_MAX'(bus.issue_wa),
                               regwrite: bus.issue_regwrite,
                               load:     bus.issue_load,
                               pcwrite:  bus.issue_pcwrite};
            end else begin
                r_pipe[1] <= ENTRY_BUBBLE;
            end
            for (int k = 2; k <= DEPTH; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
            if (w_stall_f && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CW'(1);
            end
            if (w_flush_e && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + CW'(1);
            end
        end
    end

    // Some entry fields are never inspected in some stages (load beyond E,
    // pcwrite in W, upper address bits); fold them into one sink.
    always_comb begin
        w_unused = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            w_unused = w_unused ^ (^r_pipe[k]);
        end
    end

    assign bus.stall_f   = w_stall_f;
    assign bus.stall_d   = w_stall_d;
    assign bus.flush_d   = w_flush_d;
    assign bus.flush_e   = w_flush_e;
    assign bus.fwd_sel   = w_fwd_sel;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_tracker.sv
// tb/tb_hazard_tracker.sv - directed self-checking bench for hazard_tracker
module tb_hazard_tracker;
    import hazard_tracker_pkg::*;

    localparam int AW    = 4;
    localparam int NSRC  = 3;
    localparam int DEPTH = 3;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic reset1 = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hazard_tracker_if #(.AW(AW), .NSRC(NSRC), .CW(16)) bus0 ();
    hazard_tracker_if #(.AW(AW), .NSRC(NSRC), .CW(4))  bus1 ();

    assign bus1.issue_valid    = bus0.issue_valid;
    assign bus1.issue_wa       = bus0.issue_wa;
    assign bus1.issue_regwrite = bus0.issue_regwrite;
    assign bus1.issue_load     = bus0.issue_load;
    assign bus1.issue_pcwrite  = bus0.issue_pcwrite;
    assign bus1.src_d          = bus0.src_d;
    assign bus1.src_d_used     = bus0.src_d_used;
    assign bus1.src_e          = bus0.src_e;
    assign bus1.branch_taken_e = bus0.branch_taken_e;

    hazard_tracker #(.AW(AW), .DEPTH(DEPTH), .NSRC(NSRC), .PCREG(15), .CW(16)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    hazard_tracker #(.AW(AW), .DEPTH(DEPTH), .NSRC(NSRC), .PCREG(15), .CW(4)) dut1 (
        .clk   (clk),
        .reset (reset1),
        .bus   (bus1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctrl0();
        return {28'd0, bus0.stall_f, bus0.stall_d, bus0.flush_d, bus0.flush_e};
    endfunction

    function automatic logic [31:0] ctrl1();
        return {28'd0, bus1.stall_f, bus1.stall_d, bus1.flush_d, bus1.flush_e};
    endfunction

    function automatic logic [31:0] fsel0(input int i);
        return {29'd0, bus0.fwd_sel[i*3 +: 3]};
    endfunction

    function automatic logic [31:0] fsel1(input int i);
        return {29'd0, bus1.fwd_sel[i*3 +: 3]};
    endfunction

    task automatic set_issue(input logic v, input logic [3:0] wa, input logic rw,
                             input logic ld, input logic pcw);
        bus0.issue_valid    = v;
        bus0.issue_wa       = wa;
        bus0.issue_regwrite = rw;
        bus0.issue_load     = ld;
        bus0.issue_pcwrite  = pcw;
    endtask

    task automatic set_srcd(input logic [3:0] d0, input logic [3:0] d1,
                            input logic [3:0] d2, input logic [2:0] used);
        bus0.src_d      = {d2, d1, d0};
        bus0.src_d_used = used;
    endtask

    task automatic set_srce(input logic [3:0] e0, input logic [3:0] e1, input logic [3:0] e2);
        bus0.src_e = {e2, e1, e0};
    endtask

    task automatic idle();
        set_issue(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        set_srcd(4'd0, 4'd0, 4'd0, 3'b000);
        set_srce(4'd0, 4'd0, 4'd0);
        bus0.branch_taken_e = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flush_pipe();
        idle();
        repeat (DEPTH) step();
    endtask

    // {stall_f, stall_d, flush_d, flush_e}
    localparam logic [31:0] C_NONE = 32'b0000;
    localparam logic [31:0] C_LU   = 32'b1101;
    localparam logic [31:0] C_PC   = 32'b1010;
    localparam logic [31:0] C_BR   = 32'b0011;

    initial begin
        idle();
        step();
        step();

        // Outputs forced quiet while reset is low, even with hazards presented.
        set_issue(1'b1, 4'd15, 1'b1, 1'b0, 1'b1);
        set_srcd(4'd3, 4'd3, 4'd3, 3'b111);
        bus0.branch_taken_e = 1'b1;
        #1;
        chk("rst_ctrl", ctrl0(), C_NONE);
        chk("rst_fwd", {23'd0, bus0.fwd_sel}, 32'd0);
        chk("rst_stall_cnt", {16'd0, bus0.stall_cnt}, 32'd0);
        chk("rst_flush_cnt", {16'd0, bus0.flush_cnt}, 32'd0);
        step();
        idle();
        reset = 1'b1;
        #1;
        chk("post_rst_ctrl", ctrl0(), C_NONE);
        step();

        // ADD r1 ; ADD r2,r1,r1 -> forward from M on both sources.
        set_issue(1'b1, 4'd1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("add1_ctrl", ctrl0(), C_NONE);
        step();
        set_issue(1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
        set_srcd(4'd1, 4'd1, 4'd0, 3'b011);
        #1;
        chk("add2_nostall", ctrl0(), C_NONE);
        step();
        idle();
        set_srce(4'd1, 4'd1, 4'd0);
        #1;
        chk("fwd_m_src0", fsel0(0), 32'd2);
        chk("fwd_m_src1", fsel0(1), 32'd2);
        chk("fwd_m_src2", fsel0(2), 32'd0);
        chk("fwd_m_ctrl", ctrl0(), C_NONE);
        step();
        chk("fwd_w_src0", fsel0(0), 32'd3);

        // LDR r3 ; ADD r4,r3,r5 -> one load-use bubble, then forward from W.
        flush_pipe();
        set_issue(1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
        #1;
        chk("ldr_ctrl", ctrl0(), C_NONE);
        step();
        set_issue(1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
        set_srcd(4'd3, 4'd5, 4'd0, 3'b011);
        #1;
        chk("lu_stall", ctrl0(), C_LU);
        step();
        chk("lu_release", ctrl0(), C_NONE);
        chk("lu_stall_cnt", {16'd0, bus0.stall_cnt}, 32'd1);
        chk("lu_flush_cnt", {16'd0, bus0.flush_cnt}, 32'd1);
        step();
        idle();
        set_srce(4'd3, 4'd5, 4'd0);
        #1;
        chk("lu_fwd_src0", fsel0(0), 32'd3);
        chk("lu_fwd_src1", fsel0(1), 32'd0);

        // Unused decode sources never cause a load-use stall.
        flush_pipe();
        set_issue(1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
        step();
        set_issue(1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
        set_srcd(4'd3, 4'd3, 4'd3, 3'b000);
        #1;
        chk("mask_all_off", ctrl0(), C_NONE);
        set_srcd(4'd3, 4'd5, 4'd5, 3'b110);
        #1;
        chk("mask_src0_off", ctrl0(), C_NONE);
        set_srcd(4'd5, 4'd5, 4'd3, 3'b100);
        #1;
        chk("mask_src2_on", ctrl0(), C_LU);
        step();
        chk("mask_stall_cnt", {16'd0, bus0.stall_cnt}, 32'd2);

        // Write to r15: fetch held for 3 cycles, released once it sits in W.
        flush_pipe();
        set_issue(1'b1, 4'd15, 1'b1, 1'b0, 1'b1);
        #1;
        chk("pc_c0", ctrl0(), C_PC);
        step();
        idle();
        #1;
        chk("pc_c1", ctrl0(), C_PC);
        step();
        chk("pc_c2", ctrl0(), C_PC);
        step();
        set_srce(4'd15, 4'd0, 4'd0);
        #1;
        chk("pc_release", ctrl0(), C_NONE);
        chk("pc_no_fwd_r15", fsel0(0), 32'd0);
        chk("pc_stall_cnt", {16'd0, bus0.stall_cnt}, 32'd5);

        // Taken branch with a load-use hit: branch wins.
        flush_pipe();
        set_issue(1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
        step();
        set_issue(1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
        set_srcd(4'd3, 4'd0, 4'd0, 3'b001);
        bus0.branch_taken_e = 1'b1;
        #1;
        chk("br_over_lu", ctrl0(), C_BR);
        step();
        bus0.branch_taken_e = 1'b0;
        #1;
        chk("br_flush_cnt", {16'd0, bus0.flush_cnt}, 32'd3);
        chk("br_stall_cnt", {16'd0, bus0.stall_cnt}, 32'd5);
        chk("br_bubble", ctrl0(), C_NONE);

        // r2 written by M and W at once: nearest (M) wins; r15 never forwarded.
        flush_pipe();
        set_issue(1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
        step();
        step();
        idle();
        step();
        set_srce(4'd2, 4'd15, 4'd0);
        #1;
        chk("dual_r2_src0", fsel0(0), 32'd2);
        chk("dual_r15_src1", fsel0(1), 32'd0);
        set_srce(4'd15, 4'd2, 4'd2);
        #1;
        chk("src0_r15", fsel0(0), 32'd0);
        chk("src2_r2", fsel0(2), 32'd2);

        // Reset in the middle of a PC stall discards the in-flight write.
        flush_pipe();
        set_issue(1'b1, 4'd15, 1'b1, 1'b0, 1'b1);
        step();
        idle();
        #1;
        chk("rst_mid_pre", ctrl0(), C_PC);
        reset = 1'b0;
        #1;
        chk("rst_mid_comb", ctrl0(), C_NONE);
        step();
        reset = 1'b1;
        #1;
        chk("rst_mid_drop", ctrl0(), C_NONE);
        chk("rst_mid_stall_cnt", {16'd0, bus0.stall_cnt}, 32'd0);
        step();

        // 20 load-use stalls on the CW=4 instance saturate at 15.
        reset1 = 1'b1;
        flush_pipe();
        for (int n = 0; n < 20; n++) begin
            set_issue(1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
            set_srcd(4'd0, 4'd0, 4'd0, 3'b000);
            step();
            set_issue(1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
            set_srcd(4'd3, 4'd0, 4'd0, 3'b001);
            step();
        end
        chk("sat_stall_cnt", {28'd0, bus1.stall_cnt}, 32'd15);
        chk("sat_flush_cnt", {28'd0, bus1.flush_cnt}, 32'd15);
        chk("wide_stall_cnt", {16'd0, bus0.stall_cnt}, 32'd20);
        set_issue(1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
        set_srcd(4'd0, 4'd0, 4'd0, 3'b000);
        step();
        set_issue(1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
        set_srcd(4'd3, 4'd0, 4'd0, 3'b001);
        reset1 = 1'b0;
        #1;
        chk("sat_rst_ctrl", ctrl1(), C_NONE);
        chk("ref_lu_ctrl", ctrl0(), C_LU);
        step();
        reset1 = 1'b1;
        idle();
        set_srce(4'd3, 4'd0, 4'd0);
        #1;
        chk("sat_rst_stall_cnt", {28'd0, bus1.stall_cnt}, 32'd0);
        chk("sat_rst_flush_cnt", {28'd0, bus1.flush_cnt}, 32'd0);
        chk("sat_rst_entry_gone", fsel1(0), 32'd0);
        chk("ref_entry_kept", fsel0(0), 32'd2);
        chk("ref_stall_cnt", {16'd0, bus0.stall_cnt}, 32'd21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 SHALL have parameter AW, default 4, register-address width.
REQ-002 SHALL have parameter DEPTH, default 3, number of tracked post-decode stages (1=E, 2=M, DEPTH=W); legal range 3..6.
REQ-003 SHALL have parameter NSRC, default 3, source operands per instruction (Rn, Rm, Rs).
REQ-004 SHALL have parameter PCREG, default 15, address excluded from all matching.
REQ-005 SHALL have parameter CW, default 16, width of the stall and flush performance counters.
REQ-006 clk  in  1  sole clock; all state updates on rising edge.
REQ-007 reset  in  1  synchronous, active-low reset.
REQ-008 issue_valid  in  1  decode stage holds a real instruction.
REQ-009 issue_wa  in  AW  decode destination register.
REQ-010 issue_regwrite, issue_load, issue_pcwrite  in  1 each  decode writes RF / is load / writes PC.
REQ-011 src_d  in  NSRC*AW  decode source addresses.
REQ-012 src_d_used  in  NSRC  per-source valid mask in decode.
REQ-013 src_e  in  NSRC*AW  execute-stage source addresses.
REQ-014 branch_taken_e  in  1  execute resolved a taken branch.
REQ-015 stall_f, stall_d, flush_d, flush_e  out  1 each  pipeline control.
REQ-016 fwd_sel  out  NSRC*3  per E-source select; 0 = register file, k = forward from stage k (2..DEPTH).
REQ-017 stall_cnt, flush_cnt  out  CW each  saturating performance counters.

Function
REQ-018 SHALL hold DEPTH entries {valid, wa, regwrite, load, pcwrite}; every cycle entry k moves to k+1 and the entry in stage DEPTH retires.
REQ-019 Stage-1 entry SHALL load the issue_* fields when issue_valid=1 and flush_e=0; otherwise it SHALL load a bubble (valid=0).
REQ-020 An entry SHALL be match-eligible only if valid=1, regwrite=1, and wa!=PCREG.
REQ-021 fwd_sel[i] SHALL be the smallest k in 2..DEPTH whose eligible entry wa equals src_e[i], else 0; combinational, zero latency.
REQ-022 Load-use: if the stage-1 entry is eligible with load=1 and wa matches any src_d[i] with src_d_used[i]=1, SHALL assert stall_f=stall_d=flush_e=1.
REQ-023 PC hazard: while any valid entry in stages 1..DEPTH-1 has pcwrite=1, or issue_valid with issue_pcwrite=1, SHALL assert stall_f=1 and flush_d=1.
REQ-024 branch_taken_e=1 SHALL assert flush_d=flush_e=1 and force stall_f=stall_d=0, overriding REQ-022 and REQ-023 in the same cycle.
REQ-025 PC write retiring from stage DEPTH SHALL release the PC-hazard stall the following cycle with no further bubble.
REQ-026 stall_cnt SHALL increment on every cycle with stall_f=1; flush_cnt on every cycle with flush_e=1; both saturate at 2^CW-1.
REQ-027 All outputs other than the counters SHALL be purely combinational from the current entries and inputs.
REQ-028 src_d_used=0 for source i SHALL suppress that source's load-use contribution entirely.

Reset
REQ-029 With reset=0 at a rising edge, all entries SHALL become invalid and both counters 0 on that edge.
REQ-030 While reset=0, stall_f, stall_d, flush_d and flush_e SHALL be 0 and every fwd_sel field 0.
REQ-031 Reset asserted mid-stall SHALL drop the stall the cycle after the edge; in-flight entries are discarded, never retired.

Structure
REQ-032 Entry struct typedef, the forward-select encoding constants (FWD_RF=0) and the DEPTH legal-range constants SHALL live in the shared pipeline package.
REQ-033 A single sub-module reg_match (AW-wide equality gated by eligibility) SHALL be instantiated NSRC*DEPTH times.

Verification
REQ-034 ADD r1 then ADD r2,r1,r1 back-to-back -> next cycle fwd_sel[0]=fwd_sel[1]=2; no stall.
REQ-035 LDR r3 then ADD r4,r3,r5 -> one cycle stall_f=stall_d=flush_e=1, then fwd_sel[0]=DEPTH, stall_cnt=1.
REQ-036 Write to r15 (issue_pcwrite=1, DEPTH=3) -> stall_f=flush_d=1 for 3 cycles, released after W retires.
REQ-037 branch_taken_e=1 in the same cycle as a load-use hit -> flush_d=flush_e=1, stall_f=0, flush_cnt +1.
REQ-038 r2 written by stages 2 and 3 simultaneously, src_e[0]=r2 -> fwd_sel[0]=2; src_e[0]=15 -> 0.
REQ-039 CW=4, 20 consecutive load-use stalls -> stall_cnt holds 15; then reset=0 -> counters 0, all entries invalid.
